// File: rtl/glitch_sweep_ctrl.sv
// Glitch parameter sweep sequencer: walks a (delay, width) grid, arms the glitch
// engine once per attempt, waits for it to finish, settles, then samples the target fault flag.
module glitch_sweep_ctrl #(
    parameter int DW         = 32,
    parameter int WW         = 16,
    parameter int RW         = 8,
    parameter int SETTLE_CYC = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [DW-1:0] delay_min,
    input  logic [DW-1:0] delay_max,
    input  logic [DW-1:0] delay_step,
    input  logic [WW-1:0] width_min,
    input  logic [WW-1:0] width_max,
    input  logic [WW-1:0] width_step,
    input  logic [RW-1:0] repeats,
    output logic          gen_arm,
    output logic [DW-1:0] gen_delay,
    output logic [WW-1:0] gen_width,
    input  logic          gen_done,
    input  logic          tgt_fault,
    output logic          busy,
    output logic          sweep_done,
    output logic          hit,
    output logic [DW-1:0] hit_delay,
    output logic [WW-1:0] hit_width,
    output logic [31:0]   attempts,
    output logic [2:0]    state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        WAIT   = 3'd2,
        SETTLE = 3'd3,
        CHECK  = 3'd4,
        STEP   = 3'd5,
        FINISH = 3'd6
    } state_t;

    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    state_t        state;
    logic [DW-1:0] cur_delay, dmax_q, dstep_q;
    logic [WW-1:0] cur_width, wmin_q, wmax_q, wstep_q;
    logic [RW-1:0] reps_q, rep;
    logic [SW-1:0] settle_cnt;

    assign state_dbg = state;

    // Advance arithmetic is one bit wider than the field so a step past the top never wraps.
    logic [WW:0] next_w;
    logic [DW:0] next_d;
    logic [RW:0] rep_lim;
    logic        w_ok, d_ok, rep_more;

    assign next_w   = {1'b0, cur_width} + {1'b0, wstep_q};
    assign next_d   = {1'b0, cur_delay} + {1'b0, dstep_q};
    assign w_ok     = (wstep_q != '0) && (next_w <= {1'b0, wmax_q});
    assign d_ok     = (dstep_q != '0) && (next_d <= {1'b0, dmax_q});
    assign rep_lim  = (reps_q == '0) ? {{RW{1'b0}}, 1'b1} : {1'b0, reps_q};
    assign rep_more = ({1'b0, rep} + {{RW{1'b0}}, 1'b1}) < rep_lim;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            gen_arm    <= 1'b0;
            sweep_done <= 1'b0;
            hit        <= 1'b0;
            gen_delay  <= '0;
            gen_width  <= '0;
            hit_delay  <= '0;
            hit_width  <= '0;
            attempts   <= '0;
            cur_delay  <= '0;
            cur_width  <= '0;
            dmax_q     <= '0;
            dstep_q    <= '0;
            wmin_q     <= '0;
            wmax_q     <= '0;
            wstep_q    <= '0;
            reps_q     <= '0;
            rep        <= '0;
            settle_cnt <= '0;
        end else begin
            gen_arm    <= 1'b0;
            hit        <= 1'b0;
            sweep_done <= 1'b0;
            if (abort && state != IDLE) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        dmax_q    <= delay_max;
                        dstep_q   <= delay_step;
                        wmin_q    <= width_min;
                        wmax_q    <= width_max;
                        wstep_q   <= width_step;
                        reps_q    <= repeats;
                        cur_delay <= delay_min;
                        cur_width <= width_min;
                        rep       <= '0;
                        attempts  <= '0;
                        busy      <= 1'b1;
                        gen_arm   <= 1'b1;
                        gen_delay <= delay_min;
                        gen_width <= width_min;
                        state     <= ARM;
                    end
                    ARM: state <= WAIT;
                    WAIT: if (gen_done) begin
                        if (attempts != '1) attempts <= attempts + 32'd1;
                        settle_cnt <= '0;
                        state      <= SETTLE;
                    end
                    SETTLE: begin
                        if (settle_cnt == SW'(SETTLE_CYC - 1)) state <= CHECK;
                        else settle_cnt <= settle_cnt + SW'(1);
                    end
                    CHECK: begin
                        if (tgt_fault) begin
                            hit       <= 1'b1;
                            hit_delay <= cur_delay;
                            hit_width <= cur_width;
                        end
                        state <= STEP;
                    end
                    STEP: begin
                        if (rep_more) begin
                            rep     <= rep + RW'(1);
                            gen_arm <= 1'b1;
                            state   <= ARM;
                        end else begin
                            rep <= '0;
                            if (w_ok) begin
                                cur_width <= next_w[WW-1:0];
                                gen_arm   <= 1'b1;
                                gen_width <= next_w[WW-1:0];
                                state     <= ARM;
                            end else begin
                                cur_width <= wmin_q;
                                if (d_ok) begin
                                    cur_delay <= next_d[DW-1:0];
                                    gen_arm   <= 1'b1;
                                    gen_delay <= next_d[DW-1:0];
                                    gen_width <= wmin_q;
                                    state     <= ARM;
                                end else begin
                                    sweep_done <= 1'b1;
                                    state      <= FINISH;
                                end
                            end
                        end
                    end
                    FINISH: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_glitch_sweep_ctrl.sv
// Directed bench for glitch_sweep_ctrl: grid order, hit capture, repeats, degenerate
// ranges, abort, async reset, plus a narrow-width instance for the delay overflow edge.
module tb_glitch_sweep_ctrl;

    localparam logic [2:0] S_IDLE = 3'd0, S_WAIT = 3'd2, S_SETTLE = 3'd3;

    logic        clk, rst_n, start, abort;
    logic [31:0] delay_min, delay_max, delay_step;
    logic [15:0] width_min, width_max, width_step;
    logic [7:0]  repeats;
    logic        gen_arm, gen_done, tgt_fault, busy, sweep_done, hit;
    logic [31:0] gen_delay, hit_delay, attempts;
    logic [15:0] gen_width, hit_width;
    logic [2:0]  state_dbg;
    logic        eng_done, man_done, eng_en, fault_mode;

    logic        start2;
    logic        gen_arm2, busy2, sweep_done2, hit2;
    logic [7:0]  gen_delay2, hit_delay2;
    logic [3:0]  gen_width2, hit_width2;
    logic [31:0] attempts2;
    logic [2:0]  state_dbg2;

    logic [47:0] exp_q[$];
    logic [47:0] hit_q[$];
    logic [7:0]  exp2_q[$];

    int errors, checks;
    int arm_cnt, done_cnt, hit_cnt, arm2_cnt, done2_cnt;

    assign gen_done = eng_done | man_done;

    glitch_sweep_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .delay_min(delay_min), .delay_max(delay_max), .delay_step(delay_step),
        .width_min(width_min), .width_max(width_max), .width_step(width_step),
        .repeats(repeats), .gen_arm(gen_arm), .gen_delay(gen_delay), .gen_width(gen_width),
        .gen_done(gen_done), .tgt_fault(tgt_fault), .busy(busy), .sweep_done(sweep_done),
        .hit(hit), .hit_delay(hit_delay), .hit_width(hit_width), .attempts(attempts),
        .state_dbg(state_dbg)
    );

    glitch_sweep_ctrl #(.DW(8), .WW(4), .RW(2), .SETTLE_CYC(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(1'b0),
        .delay_min(8'd250), .delay_max(8'd255), .delay_step(8'd4),
        .width_min(4'd0), .width_max(4'd0), .width_step(4'd0),
        .repeats(2'd1), .gen_arm(gen_arm2), .gen_delay(gen_delay2), .gen_width(gen_width2),
        .gen_done(1'b1), .tgt_fault(1'b0), .busy(busy2), .sweep_done(sweep_done2),
        .hit(hit2), .hit_delay(hit_delay2), .hit_width(hit_width2), .attempts(attempts2),
        .state_dbg(state_dbg2)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference enumeration of the grid: delay outer, width inner, repeats innermost.
    task automatic push_model(input longint dmin, input longint dmax, input longint dstep,
                              input longint wmin, input longint wmax, input longint wstep,
                              input longint reps);
        longint d, w, n;
        n = (reps == 0) ? 1 : reps;
        d = dmin;
        forever begin
            w = wmin;
            forever begin
                for (longint r = 0; r < n; r++) exp_q.push_back({d[31:0], w[15:0]});
                if (wstep == 0 || w + wstep > wmax) break;
                w += wstep;
            end
            if (dstep == 0 || d + dstep > dmax) break;
            d += dstep;
        end
    endtask

    // driver tasks
    task automatic start_sweep(input logic [31:0] dmin, input logic [31:0] dmax, input logic [31:0] dstep,
                               input logic [15:0] wmin, input logic [15:0] wmax, input logic [15:0] wstep,
                               input logic [7:0] reps);
        @(negedge clk);
        delay_min = dmin; delay_max = dmax; delay_step = dstep;
        width_min = wmin; width_max = wmax; width_step = wstep;
        repeats = reps; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // config must be latched; scramble it for the rest of the sweep
        delay_min = $urandom; delay_max = $urandom; delay_step = $urandom;
        width_min = 16'($urandom); width_max = 16'($urandom); width_step = 16'($urandom);
        repeats = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, busy, 1'b0);
    endtask

    task automatic wait_state(input string tag, input logic [2:0] st, input int budget);
        int n;
        n = 0;
        while (state_dbg != st && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, state_dbg, st);
    endtask

    // glitch engine model: gen_done a few cycles after each arm
    initial begin
        logic [31:0] d;
        logic [15:0] w;
        eng_done = 1'b0;
        tgt_fault = 1'b0;
        forever begin
            @(negedge clk);
            if (gen_arm && eng_en) begin
                d = gen_delay;
                w = gen_width;
                tgt_fault = 1'b0;
                repeat (4) @(negedge clk);
                eng_done = 1'b1;
                tgt_fault = fault_mode && d == 32'd20 && w == 16'd4;
                @(negedge clk);
                eng_done = 1'b0;
            end
        end
    end

    // scoreboard monitor
    initial begin
        logic [47:0] e;
        logic [7:0]  e2;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (gen_arm) begin
                    arm_cnt++;
                    checks++;
                    assert (exp_q.size() > 0) else begin
                        errors++;
                        $error("FAIL arm_unexpected observed=%0d,%0d expected=none", gen_delay, gen_width);
                    end
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("arm_point", {gen_delay, gen_width}, e);
                    end
                end
                if (sweep_done) done_cnt++;
                if (hit) begin
                    hit_cnt++;
                    check("hit_with_done", sweep_done, 1'b0);
                    checks++;
                    assert (hit_q.size() > 0) else begin
                        errors++;
                        $error("FAIL hit_unexpected observed=%0d,%0d expected=none", hit_delay, hit_width);
                    end
                    if (hit_q.size() > 0) begin
                        e = hit_q.pop_front();
                        check("hit_point", {hit_delay, hit_width}, e);
                    end
                end
                if (gen_arm2) begin
                    arm2_cnt++;
                    checks++;
                    assert (exp2_q.size() > 0) else begin
                        errors++;
                        $error("FAIL arm2_unexpected observed=%0d expected=none", gen_delay2);
                    end
                    if (exp2_q.size() > 0) begin
                        e2 = exp2_q.pop_front();
                        check("arm2_delay", gen_delay2, e2);
                    end
                end
                if (sweep_done2) done2_cnt++;
            end
        end
    end

    initial begin
        int a0, d0, h0, n;
        errors = 0; checks = 0;
        arm_cnt = 0; done_cnt = 0; hit_cnt = 0; arm2_cnt = 0; done2_cnt = 0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; start2 = 1'b0;
        man_done = 1'b0; eng_en = 1'b1; fault_mode = 1'b0;
        delay_min = '0; delay_max = '0; delay_step = '0;
        width_min = '0; width_max = '0; width_step = '0; repeats = '0;

        // reset state
        #23;
        check("rst_busy", busy, 1'b0);
        check("rst_gen_arm", gen_arm, 1'b0);
        check("rst_done", sweep_done, 1'b0);
        check("rst_hit", hit, 1'b0);
        check("rst_gen_point", {gen_delay, gen_width}, 48'd0);
        check("rst_hit_point", {hit_delay, hit_width}, 48'd0);
        check("rst_attempts", attempts, 32'd0);
        check("rst_state", state_dbg, S_IDLE);
        @(negedge clk);
        rst_n = 1'b1;

        // basic sweep
        exp_q.push_back({32'd10, 16'd2}); exp_q.push_back({32'd10, 16'd4});
        exp_q.push_back({32'd20, 16'd2}); exp_q.push_back({32'd20, 16'd4});
        exp_q.push_back({32'd30, 16'd2}); exp_q.push_back({32'd30, 16'd4});
        a0 = arm_cnt; d0 = done_cnt; h0 = hit_cnt;
        start_sweep(10, 30, 10, 2, 4, 2, 1);
        wait_idle("basic_idle", 2000);
        check("basic_arms", arm_cnt - a0, 6);
        check("basic_done", done_cnt - d0, 1);
        check("basic_hits", hit_cnt - h0, 0);
        check("basic_attempts", attempts, 32'd6);
        check("basic_q_empty", exp_q.size(), 0);

        // hit capture at (20,4)
        fault_mode = 1'b1;
        push_model(10, 30, 10, 2, 4, 2, 1);
        hit_q.push_back({32'd20, 16'd4});
        a0 = arm_cnt; d0 = done_cnt; h0 = hit_cnt;
        start_sweep(10, 30, 10, 2, 4, 2, 1);
        wait_idle("hit_idle", 2000);
        fault_mode = 1'b0;
        check("hit_count", hit_cnt - h0, 1);
        check("hit_delay", hit_delay, 32'd20);
        check("hit_width", hit_width, 16'd4);
        check("hit_done", done_cnt - d0, 1);
        check("hit_attempts", attempts, 32'd6);
        check("hit_q_empty", hit_q.size() + exp_q.size(), 0);

        // repeats with degenerate axes
        push_model(50, 40, 5, 7, 9, 0, 3);
        a0 = arm_cnt; d0 = done_cnt;
        start_sweep(50, 40, 5, 7, 9, 0, 3);
        wait_idle("rep_idle", 2000);
        check("rep_arms", arm_cnt - a0, 3);
        check("rep_attempts", attempts, 32'd3);
        check("rep_done", done_cnt - d0, 1);

        // abort coincident with gen_done
        eng_en = 1'b0;
        exp_q.push_back({32'd10, 16'd2});
        d0 = done_cnt;
        start_sweep(10, 30, 10, 2, 4, 2, 1);
        wait_state("abort_reach_wait", S_WAIT, 50);
        man_done = 1'b1; abort = 1'b1;
        @(negedge clk);
        man_done = 1'b0; abort = 1'b0;
        check("abort_state", state_dbg, S_IDLE);
        check("abort_busy", busy, 1'b0);
        check("abort_attempts", attempts, 32'd0);
        check("abort_gen_arm", gen_arm, 1'b0);
        repeat (25) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_q_empty", exp_q.size(), 0);
        eng_en = 1'b1;
        push_model(10, 30, 10, 2, 4, 2, 1);
        d0 = done_cnt;
        start_sweep(10, 30, 10, 2, 4, 2, 1);
        wait_idle("post_abort_idle", 2000);
        check("post_abort_attempts", attempts, 32'd6);
        check("post_abort_done", done_cnt - d0, 1);

        // async reset mid-SETTLE
        push_model(10, 30, 10, 2, 4, 2, 1);
        start_sweep(10, 30, 10, 2, 4, 2, 1);
        wait_state("rst_reach_settle", S_SETTLE, 100);
        #1 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_state", state_dbg, S_IDLE);
        check("arst_gen_point", {gen_delay, gen_width}, 48'd0);
        check("arst_hit_point", {hit_delay, hit_width}, 48'd0);
        check("arst_attempts", attempts, 32'd0);
        check("arst_pulses", {gen_arm, sweep_done, hit}, 3'b000);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // first start after reset; repeats=0 counts as one
        push_model(0, 3, 1, 1, 1, 0, 0);
        a0 = arm_cnt; d0 = done_cnt;
        start_sweep(0, 3, 1, 1, 1, 0, 0);
        wait_idle("after_rst_idle", 2000);
        check("after_rst_arms", arm_cnt - a0, 4);
        check("after_rst_attempts", attempts, 32'd4);
        check("after_rst_done", done_cnt - d0, 1);

        // 8-bit delay overflow boundary
        exp2_q.push_back(8'd250);
        exp2_q.push_back(8'd254);
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        n = 0;
        while (busy2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ovf_idle", busy2, 1'b0);
        check("ovf_arms", arm2_cnt, 2);
        check("ovf_done", done2_cnt, 1);
        check("ovf_last_delay", gen_delay2, 8'd254);
        check("ovf_attempts", attempts2, 32'd2);
        check("ovf_q_empty", exp2_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
